// File: rtl/pl_csr_trap_unit_pkg.sv
// Shared definitions for the machine-mode CSR/trap unit:
// CSR addresses, mstatus fields, cause codes, FSM states.
package pl_csr_trap_unit_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_MINSTRH  = 12'hB82;

  localparam int MST_MIE  = 3;
  localparam int MST_MPIE = 7;

  localparam int IRQ_MSI = 3;
  localparam int IRQ_MTI = 7;
  localparam int IRQ_MEI = 11;

  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_RW  = 2'b01;
  localparam logic [1:0] OP_RS  = 2'b10;
  localparam logic [1:0] OP_RC  = 2'b11;

  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_ECALL   = 4'd11;
  localparam logic [3:0] CAUSE_M_SW    = 4'd3;
  localparam logic [3:0] CAUSE_M_TIMER = 4'd7;
  localparam logic [3:0] CAUSE_M_EXT   = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TRAP_RDR = 2'd1,
    ST_RET_RDR  = 2'd2
  } state_e;

  function automatic logic [31:0] csr_apply(
    input logic [1:0]  op,
    input logic [31:0] old,
    input logic [31:0] wd
  );
    case (op)
      OP_RW:   csr_apply = wd;
      OP_RS:   csr_apply = old | wd;
      OP_RC:   csr_apply = old & ~wd;
      default: csr_apply = old;
    endcase
  endfunction

endpackage

// File: rtl/pl_csr_trap_unit_if.sv
// ID-stage <-> CSR/trap unit bundle.
// master = ID side, slave = CSR/trap unit.
interface pl_csr_trap_unit_if;
  import pl_csr_trap_unit_pkg::*;

  logic        csr_en;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        trap_id_v;
  logic [3:0]  cause_id;
  logic        intr_id;
  logic [31:0] trap_pc;
  logic        mret;
  logic        retire;
  logic        irq_ext;
  logic        irq_timer;
  logic [31:0] mstatus;
  logic [31:0] mie;
  logic [31:0] mip;
  logic        busy;
  logic        trap_redirect;
  logic [31:0] trap_target;

  modport master (
    output csr_en, csr_addr, csr_op, csr_wdata,
    output trap_id_v, cause_id, intr_id, trap_pc,
    output mret, retire, irq_ext, irq_timer,
    input  csr_rdata, csr_illegal,
    input  mstatus, mie, mip,
    input  busy, trap_redirect, trap_target
  );

  modport slave (
    input  csr_en, csr_addr, csr_op, csr_wdata,
    input  trap_id_v, cause_id, intr_id, trap_pc,
    input  mret, retire, irq_ext, irq_timer,
    output csr_rdata, csr_illegal,
    output mstatus, mie, mip,
    output busy, trap_redirect, trap_target
  );

endinterface

// File: rtl/pl_csr_trap_unit_csr_counter64.sv
// 64-bit free-running counter with per-half software write.
// A write to a half overrides the increment for that half.
module csr_counter64 (
  input  logic        clk,
  input  logic        clrn,
  input  logic        i_inc,
  input  logic        i_wr_lo,
  input  logic        i_wr_hi,
  input  logic [31:0] i_wdata,
  output logic [63:0] o_cnt
);

  logic [63:0] r_cnt;
  logic [63:0] w_inc;

  assign w_inc = r_cnt + {63'b0, i_inc};
  assign o_cnt = r_cnt;

  // count, software write of either half wins
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_cnt <= 64'b0;
    end else begin
      r_cnt[31:0]  <= i_wr_lo ? i_wdata : w_inc[31:0];
      r_cnt[63:32] <= i_wr_hi ? i_wdata : w_inc[63:32];
    end
  end

endmodule

// File: rtl/pl_csr_trap_unit.sv
// Machine-mode CSR file and trap/return redirect sequencer.
// Responds to the ID-stage trap/CSR bundle.
module pl_csr_trap_unit
  import pl_csr_trap_unit_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0008,
  parameter logic [31:0] MISA_VAL    = 32'h4000_1120
) (
  input logic           clk,
  input logic           clrn,
  pl_csr_trap_unit_if.slave bus
);

  state_e      r_state;
  state_e      w_state_nxt;

  logic        r_mst_mie;
  logic        r_mst_mpie;
  logic [31:0] r_mie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic        r_msip;
  logic        r_mtip;
  logic        r_meip;

  logic [63:0] w_mcycle;
  logic [63:0] w_minstret;

  logic        w_idle;
  logic        w_take_trap;
  logic        w_take_mret;
  logic        w_hit;
  logic        w_ro;
  logic [31:0] w_old;
  logic        w_wr_intent;
  logic        w_illegal;
  logic        w_we;
  logic [31:0] w_new;
  logic [31:0] w_mstatus;
  logic [31:0] w_mip;
  logic [31:0] w_vec_off;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_take_trap = w_idle & bus.trap_id_v;
  assign w_take_mret = w_idle & bus.mret & ~bus.trap_id_v;

  assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mst_mpie,
                      3'b0, r_mst_mie, 3'b0};
  assign w_mip     = {20'b0, r_meip, 3'b0, r_mtip,
                      3'b0, r_msip, 3'b0};

  // address decode: hit, read-only flag, current value
  always_comb begin
    w_hit = 1'b1;
    w_ro  = 1'b0;
    w_old = 32'b0;
    unique case (1'b1)
      (bus.csr_addr == CSR_MSTATUS):  w_old = w_mstatus;
      (bus.csr_addr == CSR_MISA): begin
        w_old = MISA_VAL;
        w_ro  = 1'b1;
      end
      (bus.csr_addr == CSR_MIE):      w_old = r_mie;
      (bus.csr_addr == CSR_MTVEC):    w_old = r_mtvec;
      (bus.csr_addr == CSR_MSCRATCH): w_old = r_mscratch;
      (bus.csr_addr == CSR_MEPC):     w_old = r_mepc;
      (bus.csr_addr == CSR_MCAUSE): begin
        w_old = r_mcause;
        w_ro  = 1'b1;
      end
      (bus.csr_addr == CSR_MIP):      w_old = w_mip;
      (bus.csr_addr == CSR_MCYCLE):   w_old = w_mcycle[31:0];
      (bus.csr_addr == CSR_MCYCLEH):  w_old = w_mcycle[63:32];
      (bus.csr_addr == CSR_MINSTRET): w_old = w_minstret[31:0];
      (bus.csr_addr == CSR_MINSTRH):  w_old = w_minstret[63:32];
      default:                        w_hit = 1'b0;
    endcase
  end

  // RS/RC with a zero operand is a pure read
  assign w_wr_intent = (bus.csr_op != OP_NOP) &&
                       !(((bus.csr_op == OP_RS) ||
                          (bus.csr_op == OP_RC)) &&
                         (bus.csr_wdata == 32'b0));

  assign w_illegal = bus.csr_en & (~w_hit | (w_ro & w_wr_intent));
  assign w_we      = bus.csr_en & w_idle & ~bus.trap_id_v &
                     ~w_illegal & w_wr_intent;
  assign w_new     = csr_apply(bus.csr_op, w_old, bus.csr_wdata);

  assign bus.csr_illegal = w_illegal;
  assign bus.csr_rdata   = w_illegal ? 32'b0 : w_old;
  assign bus.mstatus     = w_mstatus;
  assign bus.mie         = r_mie;
  assign bus.mip         = w_mip;
  assign bus.busy        = ~w_idle;

  // mstatus: trap stacks MIE, mret unstacks, else software
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_mst_mie  <= 1'b0;
      r_mst_mpie <= 1'b0;
    end else if (w_take_trap) begin
      r_mst_mpie <= r_mst_mie;
      r_mst_mie  <= 1'b0;
    end else if (w_take_mret) begin
      r_mst_mie  <= r_mst_mpie;
      r_mst_mpie <= 1'b1;
    end else if (w_we && bus.csr_addr == CSR_MSTATUS) begin
      r_mst_mie  <= w_new[MST_MIE];
      r_mst_mpie <= w_new[MST_MPIE];
    end
  end

  // trap capture of mepc/mcause
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_mepc   <= 32'b0;
      r_mcause <= 32'b0;
    end else if (w_take_trap) begin
      r_mepc   <= bus.trap_pc & ~32'h3;
      r_mcause <= {bus.intr_id, 27'b0, bus.cause_id};
    end else if (w_we && bus.csr_addr == CSR_MEPC) begin
      r_mepc   <= w_new & ~32'h3;
    end
  end

  // plain software-writable CSRs
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_mie      <= 32'b0;
      r_mtvec    <= RESET_MTVEC;
      r_mscratch <= 32'b0;
      r_msip     <= 1'b0;
    end else if (w_we) begin
      if (bus.csr_addr == CSR_MIE)
        r_mie <= w_new & MIE_MASK;
      if (bus.csr_addr == CSR_MTVEC)
        r_mtvec <= w_new;
      if (bus.csr_addr == CSR_MSCRATCH)
        r_mscratch <= w_new;
      if (bus.csr_addr == CSR_MIP)
        r_msip <= w_new[IRQ_MSI];
    end
  end

  // pending lines from the irq pins, one register stage
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_mtip <= 1'b0;
      r_meip <= 1'b0;
    end else begin
      r_mtip <= bus.irq_timer;
      r_meip <= bus.irq_ext;
    end
  end

  csr_counter64 u_mcycle (
    .clk     (clk),
    .clrn    (clrn),
    .i_inc   (1'b1),
    .i_wr_lo (w_we && bus.csr_addr == CSR_MCYCLE),
    .i_wr_hi (w_we && bus.csr_addr == CSR_MCYCLEH),
    .i_wdata (w_new),
    .o_cnt   (w_mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .clrn    (clrn),
    .i_inc   (bus.retire),
    .i_wr_lo (w_we && bus.csr_addr == CSR_MINSTRET),
    .i_wr_hi (w_we && bus.csr_addr == CSR_MINSTRH),
    .i_wdata (w_new),
    .o_cnt   (w_minstret)
  );

  // vectored offset only for interrupts with mtvec.MODE=1
  assign w_vec_off = (r_mtvec[0] & r_mcause[31]) ?
                     {26'b0, r_mcause[3:0], 2'b0} : 32'b0;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!clrn)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // FSM next state and redirect outputs
  always_comb begin
    w_state_nxt       = r_state;
    bus.trap_redirect = 1'b0;
    bus.trap_target   = 32'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.trap_id_v)
          w_state_nxt = ST_TRAP_RDR;
        else if (bus.mret)
          w_state_nxt = ST_RET_RDR;
      end
      ST_TRAP_RDR: begin
        bus.trap_redirect = 1'b1;
        bus.trap_target   = {r_mtvec[31:2], 2'b0} + w_vec_off;
        w_state_nxt       = ST_IDLE;
      end
      ST_RET_RDR: begin
        bus.trap_redirect = 1'b1;
        bus.trap_target   = r_mepc;
        w_state_nxt       = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pl_csr_trap_unit.sv
// Directed self-checking bench for pl_csr_trap_unit.
// Linear stimulus, immediate assertions at each check.
module tb_pl_csr_trap_unit;
  import pl_csr_trap_unit_pkg::*;

  localparam logic [31:0] P_MTVEC = 32'h0000_0008;
  localparam logic [31:0] P_MISA  = 32'h4000_1120;

  logic clk;
  logic clrn;
  int   n_chk;
  int   n_fail;

  pl_csr_trap_unit_if bus ();

  pl_csr_trap_unit #(
    .RESET_MTVEC (P_MTVEC),
    .MISA_VAL    (P_MISA)
  ) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag,
                    input logic [11:0] addr,
                    input logic [31:0] exp);
    bus.csr_addr = addr;
    #1;
    chk(tag, bus.csr_rdata, exp);
  endtask

  task automatic csr(input logic [1:0] op,
                     input logic [11:0] addr,
                     input logic [31:0] wd);
    bus.csr_en    = 1'b1;
    bus.csr_op    = op;
    bus.csr_addr  = addr;
    bus.csr_wdata = wd;
    tick();
    bus.csr_en    = 1'b0;
    bus.csr_op    = OP_NOP;
    bus.csr_wdata = 32'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    clrn          = 1'b0;
    bus.csr_en    = 1'b0;
    bus.csr_addr  = 12'h0;
    bus.csr_op    = OP_NOP;
    bus.csr_wdata = 32'b0;
    bus.trap_id_v = 1'b0;
    bus.cause_id  = 4'd0;
    bus.intr_id   = 1'b0;
    bus.trap_pc   = 32'b0;
    bus.mret      = 1'b0;
    bus.retire    = 1'b0;
    bus.irq_ext   = 1'b0;
    bus.irq_timer = 1'b0;

    repeat (2) tick();
    rd("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
    rd("rst_mtvec", CSR_MTVEC, P_MTVEC);
    rd("rst_mcycle", CSR_MCYCLE, 32'h0);
    chk("rst_busy", {31'b0, bus.busy}, 32'h0);
    chk("rst_redir", {31'b0, bus.trap_redirect}, 32'h0);
    chk("rst_target", bus.trap_target, 32'h0);
    clrn = 1'b1;
    tick();
    rd("mcycle_first", CSR_MCYCLE, 32'h1);

    bus.retire = 1'b1;
    repeat (3) tick();
    bus.retire = 1'b0;
    rd("minstret", CSR_MINSTRET, 32'h3);

    bus.csr_en    = 1'b1;
    bus.csr_op    = OP_RS;
    bus.csr_addr  = CSR_MIE;
    bus.csr_wdata = 32'h880;
    #1;
    chk("mie_old", bus.csr_rdata, 32'h0);
    tick();
    bus.csr_en = 1'b0;
    chk("mie_rs", bus.mie, 32'h880);
    csr(OP_RC, CSR_MIE, 32'h80);
    chk("mie_rc", bus.mie, 32'h800);

    csr(OP_RW, CSR_MCYCLE, 32'h100);
    bus.csr_en    = 1'b1;
    bus.csr_op    = OP_RS;
    bus.csr_addr  = CSR_MCYCLE;
    bus.csr_wdata = 32'h0;
    #1;
    chk("rs0_old", bus.csr_rdata, 32'h100);
    tick();
    chk("rs0_count", bus.csr_rdata, 32'h101);
    bus.csr_en = 1'b0;

    bus.csr_en    = 1'b1;
    bus.csr_op    = OP_RW;
    bus.csr_addr  = CSR_MISA;
    bus.csr_wdata = 32'hFFFF_FFFF;
    #1;
    chk("misa_wr_ill", {31'b0, bus.csr_illegal}, 32'h1);
    chk("misa_wr_rd", bus.csr_rdata, 32'h0);
    tick();
    bus.csr_op    = OP_RS;
    bus.csr_wdata = 32'h0;
    #1;
    chk("misa_rd_ill", {31'b0, bus.csr_illegal}, 32'h0);
    chk("misa_val", bus.csr_rdata, P_MISA);
    bus.csr_addr = 12'h7C0;
    #1;
    chk("unimp_ill", {31'b0, bus.csr_illegal}, 32'h1);
    bus.csr_en = 1'b0;
    bus.csr_op = OP_NOP;

    bus.irq_timer = 1'b1;
    bus.irq_ext   = 1'b1;
    tick();
    chk("mip_irq", bus.mip, 32'h880);
    csr(OP_RS, CSR_MIP, 32'h8);
    chk("mip_msip", bus.mip, 32'h888);
    bus.irq_timer = 1'b0;
    bus.irq_ext   = 1'b0;
    csr(OP_RC, CSR_MIP, 32'h8);
    chk("mip_clr", bus.mip, 32'h0);

    csr(OP_RS, CSR_MSTATUS, 32'h8);
    chk("mst_mie", bus.mstatus, 32'h0000_1808);
    bus.trap_id_v = 1'b1;
    bus.intr_id   = 1'b0;
    bus.cause_id  = CAUSE_ILLEGAL;
    bus.trap_pc   = 32'h104;
    tick();
    chk("exc_redir", {31'b0, bus.trap_redirect}, 32'h1);
    chk("exc_target", bus.trap_target, 32'h8);
    chk("exc_busy", {31'b0, bus.busy}, 32'h1);
    bus.cause_id = 4'd5;
    bus.trap_pc  = 32'h200;
    tick();
    bus.trap_id_v = 1'b0;
    chk("exc_done", {31'b0, bus.trap_redirect}, 32'h0);
    chk("exc_idle", {31'b0, bus.busy}, 32'h0);
    rd("exc_mepc", CSR_MEPC, 32'h104);
    rd("exc_mcause", CSR_MCAUSE, 32'h2);
    chk("exc_mstatus", bus.mstatus, 32'h0000_1880);

    bus.mret      = 1'b1;
    bus.csr_en    = 1'b1;
    bus.csr_op    = OP_RW;
    bus.csr_addr  = CSR_MSTATUS;
    bus.csr_wdata = 32'h0;
    tick();
    bus.mret   = 1'b0;
    bus.csr_en = 1'b0;
    bus.csr_op = OP_NOP;
    chk("ret_redir", {31'b0, bus.trap_redirect}, 32'h1);
    chk("ret_target", bus.trap_target, 32'h104);
    chk("ret_mstatus", bus.mstatus, 32'h0000_1888);
    tick();
    chk("ret_done", {31'b0, bus.trap_redirect}, 32'h0);

    csr(OP_RW, CSR_MTVEC, 32'h201);
    csr(OP_RW, CSR_MSCRATCH, 32'h55);
    bus.trap_id_v = 1'b1;
    bus.intr_id   = 1'b1;
    bus.cause_id  = CAUSE_M_EXT;
    bus.trap_pc   = 32'h303;
    bus.csr_en    = 1'b1;
    bus.csr_op    = OP_RW;
    bus.csr_addr  = CSR_MSCRATCH;
    bus.csr_wdata = 32'hAA;
    tick();
    bus.trap_id_v = 1'b0;
    bus.intr_id   = 1'b0;
    bus.csr_en    = 1'b0;
    bus.csr_op    = OP_NOP;
    chk("vec_redir", {31'b0, bus.trap_redirect}, 32'h1);
    chk("vec_target", bus.trap_target, 32'h22C);
    tick();
    rd("vec_mcause", CSR_MCAUSE, 32'h8000_000B);
    rd("vec_mscratch", CSR_MSCRATCH, 32'h55);
    rd("vec_mepc", CSR_MEPC, 32'h300);
    chk("vec_mstatus", bus.mstatus, 32'h0000_1880);

    csr(OP_RW, CSR_MCYCLEH, 32'h0);
    csr(OP_RW, CSR_MCYCLE, 32'hFFFF_FFFF);
    rd("wrap_lo0", CSR_MCYCLE, 32'hFFFF_FFFF);
    tick();
    rd("wrap_lo1", CSR_MCYCLE, 32'h0);
    rd("wrap_hi1", CSR_MCYCLEH, 32'h1);

    bus.trap_id_v = 1'b1;
    bus.cause_id  = CAUSE_ILLEGAL;
    bus.trap_pc   = 32'h10;
    tick();
    bus.trap_id_v = 1'b0;
    chk("mid_busy", {31'b0, bus.busy}, 32'h1);
    clrn = 1'b0;
    tick();
    chk("mid_redir", {31'b0, bus.trap_redirect}, 32'h0);
    chk("mid_idle", {31'b0, bus.busy}, 32'h0);
    chk("mid_target", bus.trap_target, 32'h0);
    rd("mid_mtvec", CSR_MTVEC, P_MTVEC);
    rd("mid_mstatus", CSR_MSTATUS, 32'h0000_1800);
    clrn = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
